// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit slice per stage, carry registered
// between stages, skew/de-skew registers keep each result's slices aligned.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / CHUNK;
    localparam int LAST = NSTG - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    logic             w_adv;
    logic             w_ovf;
    logic [WIDTH-1:0] w_pa [NSTG];
    logic [WIDTH-1:0] w_pb [NSTG];
    logic [WIDTH-1:0] w_ps [NSTG];
    logic [WIDTH-1:0] w_ns [NSTG];
    logic             w_pc [NSTG];
    logic             w_pv [NSTG];
    logic             w_nc [NSTG];
    logic [CHUNK:0]   w_sl [NSTG];

    // Stage k holds operands still to be resolved (skew) and finished low
    // slices (de-skew); the last stage doubles as the output register.
    logic [WIDTH-1:0] r_a [NSTG];
    logic [WIDTH-1:0] r_b [NSTG];
    logic [WIDTH-1:0] r_s [NSTG];
    logic             r_c [NSTG];
    logic             r_v [NSTG];
    logic             r_ovf;

    assign w_adv    = !r_v[LAST] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_pa[0] = a;
        w_pb[0] = sub ? ~b : b;
        w_ps[0] = '0;
        w_pc[0] = cin ^ sub;
        w_pv[0] = in_valid && w_adv;
        for (int k = 1; k < NSTG; k++) begin
            w_pa[k] = r_a[k-1];
            w_pb[k] = r_b[k-1];
            w_ps[k] = r_s[k-1];
            w_pc[k] = r_c[k-1];
            w_pv[k] = r_v[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            w_sl[k] = {1'b0, w_pa[k][k*CHUNK +: CHUNK]}
                    + {1'b0, w_pb[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, w_pc[k]};
            w_ns[k] = w_ps[k];
            w_ns[k][k*CHUNK +: CHUNK] = w_sl[k][CHUNK-1:0];
            w_nc[k] = w_sl[k][CHUNK];
        end
        w_ovf = (w_pa[LAST][WIDTH-1] == w_pb[LAST][WIDTH-1])
             && (w_ns[LAST][WIDTH-1] != w_pa[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < LAST; k++) begin
                r_a[k] <= w_pa[k];
                r_b[k] <= w_pb[k];
                r_s[k] <= w_ns[k];
                r_c[k] <= w_nc[k];
                r_v[k] <= w_pv[k];
            end
            r_v[LAST] <= w_pv[LAST];
            // Result registers only change when a real op lands.
            if (w_pv[LAST]) begin
                r_s[LAST] <= w_ns[LAST];
                r_c[LAST] <= w_nc[LAST];
                r_ovf     <= w_ovf;
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule
